mem_rd_arbiter: RTL and testbench
=================================

// Module: mem_rd_arbiter
// PURPOSE
//  Shares the core's single memory read port (mem_rd_addr/_valid/_data/_ack) between
//  instruction fetch (IF) and the load unit (LS). One outstanding read at a time;
//  grant held until memory acks. Sits between the instruction handler/load path and memory.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  TIMEOUT_CYC   16  max cycles waiting for mem_rd_ack; 0 = watchdog disabled
// PORTS
//  clk               in   1       clock, all state on rising edge
//  reset             in   1       asynchronous, active-high
//  if_rd_addr        in   ADDR_W  fetch read address
//  if_rd_addr_valid  in   1       fetch request
//  if_rd_data        out  DATA_W  fetch read data, valid with if_rd_ack
//  if_rd_ack         out  1       one-cycle completion pulse to fetch
//  ls_rd_addr        in   ADDR_W  load read address
//  ls_rd_addr_valid  in   1       load request
//  ls_rd_data        out  DATA_W  load read data, valid with ls_rd_ack
//  ls_rd_ack         out  1       one-cycle completion pulse to load unit
//  rd_err            out  1       pulses with the ack of a timed-out read
//  mem_rd_addr       out  ADDR_W  address to memory
//  mem_rd_addr_valid out  1       read request to memory
//  mem_rd_data       in   DATA_W  memory data, sampled when mem_rd_ack=1
//  mem_rd_ack        in   1       memory completion, one cycle
//  arb_busy          out  1       1 in BUSY or RESP
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, wait counter 0, last_grant=LS; in-flight read dropped.
//  - All outputs registered. FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any *_rd_addr_valid at edge N: latch winner + its address; BUSY at N+1 with
//    mem_rd_addr_valid=1, mem_rd_addr=latched addr (held stable through BUSY).
//  - Priority (default): LS over IF when both valid in same cycle.
//  - BUSY: mem_rd_ack at edge M -> capture mem_rd_data; at M+1 state RESP,
//    mem_rd_addr_valid=0, winner's ack=1 and data=captured value for exactly one cycle.
//    Non-winner ack stays 0; non-winner data holds its previous value.
//  - RESP: requests ignored (requester still shows valid); IDLE at M+2; new arbitration
//    from M+2. Min request-to-ack latency = 2 cycles + memory latency; max rate 1 read/3 cyc.
//  - Requester protocol: hold valid and address stable until ack; drop or re-issue after.
//    Valid dropped before grant -> no access. Valid dropped during BUSY -> read still
//    completes and ack still pulses.
//  - mem_rd_ack outside BUSY: ignored. Address input changes during BUSY: ignored.
//  - Watchdog (TIMEOUT_CYC>0): counter clears on BUSY entry, increments each BUSY cycle
//    without ack; on reaching TIMEOUT_CYC -> RESP with winner ack=1, data=0, rd_err=1
//    (one cycle), mem_rd_addr_valid=0. Ack arriving in same cycle as expiry wins (no error).
//  - Counter width $clog2(TIMEOUT_CYC+1); never wraps (saturates at terminal count).
// CONFIGURATION
//  MEM_RD_ARB_RR_EN defined: round-robin on conflict -- simultaneous requests go to the
//    requester not in last_grant; last_grant updated on every grant; first conflict after
//    reset goes to IF. Single requester always granted regardless of last_grant.
//  MEM_RD_ARB_RR_EN undefined: fixed priority LS > IF; last_grant unused.
// TESTING
//  - Reset held 3 cycles -> all outputs 0, arb_busy=0; release, no valids -> stays IDLE.
//  - IF valid addr=0x0 alone, mem acks 2 cyc after mem_rd_addr_valid with 0x00100133 ->
//    mem_rd_addr=0x0, if_rd_ack 1 cycle, if_rd_data=0x00100133, ls_rd_ack=0.
//  - IF addr=0x40 and LS addr=0x80 valid same cycle, no RR -> LS served first (addr 0x80),
//    then IF (0x40); with MEM_RD_ARB_RR_EN -> IF first, then LS; repeat conflict alternates.
//  - TIMEOUT_CYC=4, memory never acks -> mem_rd_addr_valid high 4 cycles, then ack=1,
//    data=0, rd_err=1 one cycle; ack on exactly 4th cycle -> rd_err=0, real data returned.
//  - Reset asserted mid-BUSY -> outputs 0 asynchronously; late mem_rd_ack after release
//    ignored, no requester ack.
//  - mem_rd_ack pulsed while IDLE, and LS valid dropped mid-BUSY -> former ignored;
//    latter still yields ls_rd_ack once.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Arbitrates the single memory read port between instruction fetch and the load unit.
// Optional round-robin conflict resolution is enabled by defining MEM_RD_ARB_RR_EN.
module mem_rd_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_rd_addr,
    input  logic              if_rd_addr_valid,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_rd_ack,
    input  logic [ADDR_W-1:0] ls_rd_addr,
    input  logic              ls_rd_addr_valid,
    output logic [DATA_W-1:0] ls_rd_data,
    output logic              ls_rd_ack,
    output logic              rd_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_addr_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ack,
    output logic              arb_busy
);

    // state  | meaning
    // S_IDLE | no read in flight, arbitrate on any request
    // S_BUSY | request presented to memory, waiting for ack or watchdog expiry
    // S_RESP | one-cycle completion pulse to the winning requester
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam bit WD_EN  = (TIMEOUT_CYC > 0);
    localparam int CNT_W  = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int LAST_I = WD_EN ? TIMEOUT_CYC - 1 : 0;
    localparam int MAX_I  = WD_EN ? TIMEOUT_CYC : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_I);

    state_t            state_q, state_d;
    logic              grant_ls_q, grant_ls_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_data_q, ls_data_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              pick_ls;
    logic              expire;

`ifdef MEM_RD_ARB_RR_EN
    logic last_ls_q, last_ls_d;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        pick_ls = ls_rd_addr_valid && (!if_rd_addr_valid || !last_ls_q);
    end

    always_comb begin
        last_ls_d = last_ls_q;
        if (state_q == S_IDLE && (if_rd_addr_valid || ls_rd_addr_valid)) begin
            last_ls_d = pick_ls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ls_q <= 1'b1;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    always_comb begin
        pick_ls = ls_rd_addr_valid;
    end
`endif

    always_comb begin
        expire = WD_EN && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d     = state_q;
        grant_ls_d  = grant_ls_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_valid_d = mem_valid_q;
        if_data_d   = if_data_q;
        ls_data_d   = ls_data_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_rd_addr_valid || ls_rd_addr_valid) begin
                    state_d     = S_BUSY;
                    grant_ls_d  = pick_ls;
                    cnt_d       = '0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = pick_ls ? ls_rd_addr : if_rd_addr;
                end
            end
            S_BUSY: begin
                // A real ack takes precedence over a simultaneous watchdog expiry.
                if (mem_rd_ack || expire) begin
                    state_d     = S_RESP;
                    mem_valid_d = 1'b0;
                    err_d       = !mem_rd_ack;
                    if (grant_ls_q) begin
                        ls_ack_d  = 1'b1;
                        ls_data_d = mem_rd_ack ? mem_rd_data : '0;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = mem_rd_ack ? mem_rd_data : '0;
                    end
                end
                if (!mem_rd_ack && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_ls_q  <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_valid_q <= 1'b0;
            if_data_q   <= '0;
            ls_data_q   <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_ls_q  <= grant_ls_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_valid_q <= mem_valid_d;
            if_data_q   <= if_data_d;
            ls_data_q   <= ls_data_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_rd_addr       = mem_addr_q;
    assign mem_rd_addr_valid = mem_valid_q;
    assign if_rd_data        = if_data_q;
    assign ls_rd_data        = ls_data_q;
    assign if_rd_ack         = if_ack_q;
    assign ls_rd_ack         = ls_ack_q;
    assign rd_err            = err_q;
    assign arb_busy          = busy_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter (watchdog set to 4 cycles); follows MEM_RD_ARB_RR_EN.
module tb_mem_rd_arbiter;

`ifdef MEM_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] if_rd_addr;
    logic        if_rd_addr_valid;
    logic [31:0] if_rd_data;
    logic        if_rd_ack;
    logic [31:0] ls_rd_addr;
    logic        ls_rd_addr_valid;
    logic [31:0] ls_rd_data;
    logic        ls_rd_ack;
    logic        rd_err;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_addr_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_ack;
    logic        arb_busy;

    int vectors = 0;
    int miscompares = 0;

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_rd_addr        (if_rd_addr),
        .if_rd_addr_valid  (if_rd_addr_valid),
        .if_rd_data        (if_rd_data),
        .if_rd_ack         (if_rd_ack),
        .ls_rd_addr        (ls_rd_addr),
        .ls_rd_addr_valid  (ls_rd_addr_valid),
        .ls_rd_data        (ls_rd_data),
        .ls_rd_ack         (ls_rd_ack),
        .rd_err            (rd_err),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_addr_valid (mem_rd_addr_valid),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_ack        (mem_rd_ack),
        .arb_busy          (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_ack"},   {31'd0, if_rd_ack}, 32'd0);
        chk({tag, ".ls_ack"},   {31'd0, ls_rd_ack}, 32'd0);
        chk({tag, ".err"},      {31'd0, rd_err}, 32'd0);
        chk({tag, ".mvalid"},   {31'd0, mem_rd_addr_valid}, 32'd0);
        chk({tag, ".maddr"},    mem_rd_addr, 32'd0);
        chk({tag, ".if_data"},  if_rd_data, 32'd0);
        chk({tag, ".ls_data"},  ls_rd_data, 32'd0);
        chk({tag, ".busy"},     {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ack_of(input bit ls);
        return {31'd0, ls ? ls_rd_ack : if_rd_ack};
    endfunction

    function automatic logic [31:0] data_of(input bit ls);
        return ls ? ls_rd_data : if_rd_data;
    endfunction

    bit first_ls;

    initial begin
        if_rd_addr = '0; if_rd_addr_valid = 1'b0;
        ls_rd_addr = '0; ls_rd_addr_valid = 1'b0;
        mem_rd_data = '0; mem_rd_ack = 1'b0;

        // reset held 3 cycles, then idle with no requests
        do_reset();
        chk_all_zero("rst");
        tick(); tick();
        chk("idle.busy",   {31'd0, arb_busy}, 32'd0);
        chk("idle.mvalid", {31'd0, mem_rd_addr_valid}, 32'd0);

        // single IF fetch, memory acks 2 cycles after request
        if_rd_addr = 32'h0; if_rd_addr_valid = 1'b1;
        tick();
        chk("if.b1.mvalid", {31'd0, mem_rd_addr_valid}, 32'd1);
        chk("if.b1.maddr",  mem_rd_addr, 32'h0);
        chk("if.b1.busy",   {31'd0, arb_busy}, 32'd1);
        tick();
        chk("if.b2.mvalid", {31'd0, mem_rd_addr_valid}, 32'd1);
        chk("if.b2.ack",    {31'd0, if_rd_ack}, 32'd0);
        tick();
        mem_rd_ack = 1'b1; mem_rd_data = 32'h00100133;
        tick();
        mem_rd_ack = 1'b0; mem_rd_data = 32'hFFFF_FFFF;
        chk("if.resp.ack",    {31'd0, if_rd_ack}, 32'd1);
        chk("if.resp.data",   if_rd_data, 32'h00100133);
        chk("if.resp.lsack",  {31'd0, ls_rd_ack}, 32'd0);
        chk("if.resp.lsdata", ls_rd_data, 32'd0);
        chk("if.resp.mvalid", {31'd0, mem_rd_addr_valid}, 32'd0);
        chk("if.resp.err",    {31'd0, rd_err}, 32'd0);
        chk("if.resp.busy",   {31'd0, arb_busy}, 32'd1);
        if_rd_addr_valid = 1'b0;
        tick();
        chk("if.idle.ack",  {31'd0, if_rd_ack}, 32'd0);
        chk("if.idle.busy", {31'd0, arb_busy}, 32'd0);
        chk("if.idle.data", if_rd_data, 32'h00100133);

        // conflict from fresh reset: fixed priority -> LS, round-robin -> IF
        do_reset();
        first_ls = !RR;
        if_rd_addr = 32'h40; if_rd_addr_valid = 1'b1;
        ls_rd_addr = 32'h80; ls_rd_addr_valid = 1'b1;
        tick();
        chk("c1.maddr", mem_rd_addr, first_ls ? 32'h80 : 32'h40);
        mem_rd_ack = 1'b1; mem_rd_data = 32'hAAAA0001;
        tick();
        mem_rd_ack = 1'b0;
        chk("c1.ack",    ack_of(first_ls), 32'd1);
        chk("c1.oack",   ack_of(!first_ls), 32'd0);
        chk("c1.data",   data_of(first_ls), 32'hAAAA0001);
        chk("c1.odata",  data_of(!first_ls), 32'd0);
        if (first_ls) ls_rd_addr_valid = 1'b0; else if_rd_addr_valid = 1'b0;
        tick();
        chk("c1.idle.busy",   {31'd0, arb_busy}, 32'd0);
        chk("c1.idle.mvalid", {31'd0, mem_rd_addr_valid}, 32'd0);
        tick();
        chk("c2.maddr", mem_rd_addr, first_ls ? 32'h40 : 32'h80);
        mem_rd_ack = 1'b1; mem_rd_data = 32'hBBBB0002;
        tick();
        mem_rd_ack = 1'b0;
        chk("c2.ack",   ack_of(!first_ls), 32'd1);
        chk("c2.oack",  ack_of(first_ls), 32'd0);
        chk("c2.data",  data_of(!first_ls), 32'hBBBB0002);
        chk("c2.odata", data_of(first_ls), 32'hAAAA0001);
        if (first_ls) if_rd_addr_valid = 1'b0; else ls_rd_addr_valid = 1'b0;
        tick();

        // repeat conflict: same winner as the first conflict in both modes; memory never acks
        if_rd_addr_valid = 1'b1; ls_rd_addr_valid = 1'b1;
        tick();
        chk("c3.maddr", mem_rd_addr, first_ls ? 32'h80 : 32'h40);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to.b%0d.mvalid", i), {31'd0, mem_rd_addr_valid}, 32'd1);
            chk($sformatf("to.b%0d.ack", i), ack_of(first_ls), 32'd0);
            if (i < 4) tick();
        end
        tick();
        chk("to.ack",    ack_of(first_ls), 32'd1);
        chk("to.oack",   ack_of(!first_ls), 32'd0);
        chk("to.data",   data_of(first_ls), 32'd0);
        chk("to.err",    {31'd0, rd_err}, 32'd1);
        chk("to.mvalid", {31'd0, mem_rd_addr_valid}, 32'd0);
        if (first_ls) ls_rd_addr_valid = 1'b0; else if_rd_addr_valid = 1'b0;
        tick();
        chk("to.idle.err", {31'd0, rd_err}, 32'd0);
        chk("to.idle.ack", ack_of(first_ls), 32'd0);

        // ack on exactly the 4th BUSY cycle beats the watchdog
        tick();
        chk("a4.maddr", mem_rd_addr, first_ls ? 32'h40 : 32'h80);
        tick(); tick(); tick();
        chk("a4.b4.mvalid", {31'd0, mem_rd_addr_valid}, 32'd1);
        mem_rd_ack = 1'b1; mem_rd_data = 32'h12345678;
        tick();
        mem_rd_ack = 1'b0;
        chk("a4.ack",  ack_of(!first_ls), 32'd1);
        chk("a4.err",  {31'd0, rd_err}, 32'd0);
        chk("a4.data", data_of(!first_ls), 32'h12345678);
        if_rd_addr_valid = 1'b0; ls_rd_addr_valid = 1'b0;
        tick();

        // reset mid-BUSY clears outputs asynchronously; late ack ignored
        if_rd_addr = 32'h300; if_rd_addr_valid = 1'b1;
        tick();
        chk("mr.b1.mvalid", {31'd0, mem_rd_addr_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("mr.async");
        tick();
        if_rd_addr_valid = 1'b0;
        tick();
        reset = 1'b0;
        mem_rd_ack = 1'b1; mem_rd_data = 32'h5555AAAA;
        tick();
        mem_rd_ack = 1'b0;
        chk("mr.late.ifack", {31'd0, if_rd_ack}, 32'd0);
        chk("mr.late.lsack", {31'd0, ls_rd_ack}, 32'd0);
        chk("mr.late.busy",  {31'd0, arb_busy}, 32'd0);
        tick();
        chk("mr.late2.ifack", {31'd0, if_rd_ack}, 32'd0);
        chk("mr.late2.data",  if_rd_data, 32'd0);

        // stray ack while IDLE
        mem_rd_ack = 1'b1; mem_rd_data = 32'hDEAD0000;
        tick();
        mem_rd_ack = 1'b0;
        chk_all_zero("stray");

        // LS valid dropped mid-BUSY still completes; address change ignored
        ls_rd_addr = 32'h100; ls_rd_addr_valid = 1'b1;
        tick();
        chk("drop.maddr", mem_rd_addr, 32'h100);
        ls_rd_addr_valid = 1'b0; ls_rd_addr = 32'h200;
        tick();
        chk("drop.b2.maddr",  mem_rd_addr, 32'h100);
        chk("drop.b2.mvalid", {31'd0, mem_rd_addr_valid}, 32'd1);
        mem_rd_ack = 1'b1; mem_rd_data = 32'hCAFE0001;
        tick();
        mem_rd_ack = 1'b0;
        chk("drop.ack",   {31'd0, ls_rd_ack}, 32'd1);
        chk("drop.data",  ls_rd_data, 32'hCAFE0001);
        chk("drop.ifack", {31'd0, if_rd_ack}, 32'd0);
        tick();
        chk("drop.once", {31'd0, ls_rd_ack}, 32'd0);
        chk("drop.busy", {31'd0, arb_busy}, 32'd0);
        tick();
        chk("drop.idle.mvalid", {31'd0, mem_rd_addr_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
